// File: rtl/ascon_bdi_packer_if.sv
// Shared type package plus the byte-stream and bdi-word interfaces
// used between the host front end, the packer and ascon_core.
package ascon_bdi_pkg;
  typedef enum logic [2:0] {
    D_INVALID = 3'd0,
    D_NONCE   = 3'd1,
    D_AD      = 3'd2,
    D_MSG     = 3'd3,
    D_TAG     = 3'd4
  } data_e;
endpackage

interface ascon_byte_if;
  import ascon_bdi_pkg::*;
  logic [7:0] s_byte;
  logic       s_valid;
  logic       s_ready;
  data_e      s_type;
  logic       s_last;
  logic       s_eoi;

  modport master (
    output s_byte, s_valid, s_type, s_last, s_eoi,
    input  s_ready
  );
  modport slave (
    input  s_byte, s_valid, s_type, s_last, s_eoi,
    output s_ready
  );
endinterface

interface ascon_bdi_if #(
  parameter int CCW = 32
);
  import ascon_bdi_pkg::*;
  logic [CCW-1:0]   bdi;
  logic [CCW/8-1:0] bdi_valid;
  logic             bdi_ready;
  data_e            bdi_type;
  logic             bdi_eot;
  logic             bdi_eoi;

  modport master (
    output bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi,
    input  bdi_ready
  );
  modport slave (
    input  bdi, bdi_valid, bdi_type, bdi_eot, bdi_eoi,
    output bdi_ready
  );
endinterface

// File: rtl/ascon_bdi_packer.sv
// Packs a typed byte stream into CCW-bit bdi words with byte mask,
// type, end-of-type and end-of-input flags for ascon_core.
module ascon_bdi_packer
  import ascon_bdi_pkg::*;
#(
  parameter int CCW = 32
) (
  input logic         clk,
  input logic         rst,
  ascon_byte_if.slave s,
  ascon_bdi_if.master m
);
  localparam int BYTES = CCW / 8;
  localparam int CW    = $clog2(BYTES);

  logic [CCW-1:0]   acc_data_q, acc_data_d;
  logic [BYTES-1:0] acc_mask_q, acc_mask_d;
  data_e            acc_type_q, acc_type_d;
  logic             acc_eot_q, acc_eot_d;
  logic             acc_eoi_q, acc_eoi_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             acc_full_q, acc_full_d;

  logic [CCW-1:0]   bdi_q, bdi_d;
  logic [BYTES-1:0] bdi_valid_q, bdi_valid_d;
  data_e            bdi_type_q, bdi_type_d;
  logic             bdi_eot_q, bdi_eot_d;
  logic             bdi_eoi_q, bdi_eoi_d;

  logic xfer;
  logic brk;
  logic rdy;
  logic take;

  always_comb begin
    acc_data_d  = acc_data_q;
    acc_mask_d  = acc_mask_q;
    acc_type_d  = acc_type_q;
    acc_eot_d   = acc_eot_q;
    acc_eoi_d   = acc_eoi_q;
    cnt_d       = cnt_q;
    acc_full_d  = acc_full_q;
    bdi_d       = bdi_q;
    bdi_valid_d = bdi_valid_q;
    bdi_type_d  = bdi_type_q;
    bdi_eot_d   = bdi_eot_q;
    bdi_eoi_d   = bdi_eoi_q;

    xfer = acc_full_q
         && (bdi_valid_q == '0 || m.bdi_ready);
    // A type switch mid-word closes the partial word first
    brk  = s.s_valid && !acc_full_q
         && cnt_q != '0
         && s.s_type != acc_type_q;
    rdy  = !acc_full_q && !brk;
    take = s.s_valid && rdy;

    if (xfer) begin
      bdi_d       = acc_data_q;
      bdi_valid_d = acc_mask_q;
      bdi_type_d  = acc_type_q;
      bdi_eot_d   = acc_eot_q;
      bdi_eoi_d   = acc_eoi_q;
      acc_data_d  = '0;
      acc_mask_d  = '0;
      acc_type_d  = D_INVALID;
      acc_eot_d   = 1'b0;
      acc_eoi_d   = 1'b0;
      cnt_d       = '0;
      acc_full_d  = 1'b0;
    end else if (bdi_valid_q != '0
                 && m.bdi_ready) begin
      bdi_valid_d = '0;
    end

    if (brk) begin
      acc_full_d = 1'b1;
      acc_eot_d  = 1'b0;
      acc_eoi_d  = 1'b0;
    end else if (take) begin
      acc_data_d[{cnt_q, 3'b000} +: 8] = s.s_byte;
      acc_mask_d[cnt_q] = 1'b1;
      if (cnt_q == '0)
        acc_type_d = s.s_type;
      acc_eot_d  = s.s_last;
      acc_eoi_d  = s.s_last && s.s_eoi;
      cnt_d      = cnt_q + 1'b1;
      acc_full_d = (cnt_q == CW'(BYTES - 1))
                 || s.s_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_data_q  <= '0;
      acc_mask_q  <= '0;
      acc_type_q  <= D_INVALID;
      acc_eot_q   <= 1'b0;
      acc_eoi_q   <= 1'b0;
      cnt_q       <= '0;
      acc_full_q  <= 1'b0;
      bdi_q       <= '0;
      bdi_valid_q <= '0;
      bdi_type_q  <= D_INVALID;
      bdi_eot_q   <= 1'b0;
      bdi_eoi_q   <= 1'b0;
    end else begin
      acc_data_q  <= acc_data_d;
      acc_mask_q  <= acc_mask_d;
      acc_type_q  <= acc_type_d;
      acc_eot_q   <= acc_eot_d;
      acc_eoi_q   <= acc_eoi_d;
      cnt_q       <= cnt_d;
      acc_full_q  <= acc_full_d;
      bdi_q       <= bdi_d;
      bdi_valid_q <= bdi_valid_d;
      bdi_type_q  <= bdi_type_d;
      bdi_eot_q   <= bdi_eot_d;
      bdi_eoi_q   <= bdi_eoi_d;
    end
  end

  assign s.s_ready   = rdy;
  assign m.bdi       = bdi_q;
  assign m.bdi_valid = bdi_valid_q;
  assign m.bdi_type  = bdi_type_q;
  assign m.bdi_eot   = bdi_eot_q;
  assign m.bdi_eoi   = bdi_eoi_q;
endmodule

// File: tb/tb_ascon_bdi_packer.sv
// Bench for ascon_bdi_packer: 32- and 64-bit instances, byte tables,
// stall/type-switch/reset sequences, word scoreboard per instance.
module tb_ascon_bdi_packer;
  import ascon_bdi_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  mask;
    data_e       typ;
    logic        eot;
    logic        eoi;
  } exp_t;

  typedef struct {
    bit         w64;
    data_e      t;
    logic [7:0] b;
    bit         last;
    bit         eoi;
    bit         push;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q32[$];
  exp_t q64[$];
  vec_t tbl[$];
  exp_t m32_e;
  exp_t m64_e;

  always #5 clk = ~clk;

  ascon_byte_if b32 ();
  ascon_byte_if b64 ();
  ascon_bdi_if #(.CCW(32)) o32 ();
  ascon_bdi_if #(.CCW(64)) o64 ();

  ascon_bdi_packer #(.CCW(32)) u32 (
    .clk(clk), .rst(rst), .s(b32.slave), .m(o32.master)
  );
  ascon_bdi_packer #(.CCW(64)) u64 (
    .clk(clk), .rst(rst), .s(b64.slave), .m(o64.master)
  );

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(logic [63:0] d,
      logic [7:0] m, data_e t, logic eot, logic eoi);
    exp_t e;
    e.data = d; e.mask = m; e.typ = t;
    e.eot = eot; e.eoi = eoi;
    return e;
  endfunction

  task automatic add(bit w64, data_e t, logic [7:0] b,
      bit last, bit eoi, bit push, exp_t e);
    vec_t v;
    v.w64 = w64; v.t = t; v.b = b; v.last = last;
    v.eoi = eoi; v.push = push; v.e = e;
    tbl.push_back(v);
  endtask

  task automatic set_in(bit w64, data_e t, logic [7:0] b,
      bit last, bit eoi);
    if (w64) begin
      b64.s_byte = b; b64.s_type = t; b64.s_last = last;
      b64.s_eoi = eoi; b64.s_valid = 1'b1;
    end else begin
      b32.s_byte = b; b32.s_type = t; b32.s_last = last;
      b32.s_eoi = eoi; b32.s_valid = 1'b1;
    end
  endtask

  task automatic send(bit w64, data_e t, logic [7:0] b,
      bit last, bit eoi);
    int n = 0;
    bit r;
    set_in(w64, t, b, last, eoi);
    forever begin
      @(negedge clk);
      r = w64 ? b64.s_ready : b32.s_ready;
      @(posedge clk);
      #1;
      if (r) break;
      if (++n > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout byte %h", b);
        break;
      end
    end
    b32.s_valid = 1'b0;
    b64.s_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && o32.bdi_valid != '0 && o32.bdi_ready) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL w32_extra got %h want none", o32.bdi);
      end else begin
        m32_e = q32.pop_front();
        chk("w32_data", 64'(o32.bdi), m32_e.data);
        chk("w32_mask", 64'(o32.bdi_valid), 64'(m32_e.mask));
        chk("w32_type", 64'(o32.bdi_type), 64'(m32_e.typ));
        chk("w32_eot", 64'(o32.bdi_eot), 64'(m32_e.eot));
        chk("w32_eoi", 64'(o32.bdi_eoi), 64'(m32_e.eoi));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && o64.bdi_valid != '0 && o64.bdi_ready) begin
      if (q64.size() == 0) begin
        checks++; errors++;
        $display("FAIL w64_extra got %h want none", o64.bdi);
      end else begin
        m64_e = q64.pop_front();
        chk("w64_data", o64.bdi, m64_e.data);
        chk("w64_mask", 64'(o64.bdi_valid), 64'(m64_e.mask));
        chk("w64_type", 64'(o64.bdi_type), 64'(m64_e.typ));
        chk("w64_eot", 64'(o64.bdi_eot), 64'(m64_e.eot));
        chk("w64_eoi", 64'(o64.bdi_eoi), 64'(m64_e.eoi));
      end
    end
  end

  initial begin
    logic [40:0] snap;
    bit          saw_low;
    int          n;
    exp_t        z;
    z = mk(64'h0, 8'h0, D_INVALID, 1'b0, 1'b0);

    b32.s_valid = 1'b0; b32.s_byte = '0; b32.s_type = D_AD;
    b32.s_last = 1'b0; b32.s_eoi = 1'b0;
    b64.s_valid = 1'b0; b64.s_byte = '0; b64.s_type = D_AD;
    b64.s_last = 1'b0; b64.s_eoi = 1'b0;
    o32.bdi_ready = 1'b1;
    o64.bdi_ready = 1'b1;

    add(0, D_AD, 8'h11, 0, 0, 0, z);
    add(0, D_AD, 8'h22, 0, 0, 0, z);
    add(0, D_AD, 8'h33, 0, 0, 0, z);
    add(0, D_AD, 8'h44, 1, 0, 1,
        mk(64'h44332211, 8'hF, D_AD, 1, 0));
    add(0, D_MSG, 8'hA0, 0, 0, 0, z);
    add(0, D_MSG, 8'hA1, 0, 0, 0, z);
    add(0, D_MSG, 8'hA2, 0, 0, 0, z);
    add(0, D_MSG, 8'hA3, 0, 0, 1,
        mk(64'hA3A2A1A0, 8'hF, D_MSG, 0, 0));
    add(0, D_MSG, 8'hA4, 1, 1, 1,
        mk(64'h000000A4, 8'h1, D_MSG, 1, 1));
    for (int i = 0; i < 16; i++)
      add(1, D_NONCE, 8'(i), i == 15, 0,
          i == 7 || i == 15,
          i == 7 ? mk(64'h0706050403020100, 8'hFF,
                      D_NONCE, 0, 0)
                 : mk(64'h0F0E0D0C0B0A0908, 8'hFF,
                      D_NONCE, 1, 0));

    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bdi", 64'(o32.bdi), 64'h0);
    chk("rst_valid", 64'(o32.bdi_valid), 64'h0);
    chk("rst_type", 64'(o32.bdi_type), 64'(D_INVALID));
    chk("rst_eot_eoi", {o32.bdi_eot, o32.bdi_eoi}, 64'h0);
    chk("rst_sready", 64'(o32.bdi_valid == '0 && b32.s_ready),
        64'h1);
    chk("rst_valid64", 64'(o64.bdi_valid), 64'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;

    foreach (tbl[i]) begin
      if (tbl[i].push) begin
        if (tbl[i].w64) q64.push_back(tbl[i].e);
        else q32.push_back(tbl[i].e);
      end
      send(tbl[i].w64, tbl[i].t, tbl[i].b,
           tbl[i].last, tbl[i].eoi);
    end

    // stalled sink while 12 bytes stream in
    repeat (4) @(posedge clk);
    #1;
    q32.push_back(mk(64'h13121110, 8'hF, D_MSG, 0, 0));
    q32.push_back(mk(64'h17161514, 8'hF, D_MSG, 0, 0));
    q32.push_back(mk(64'h1B1A1918, 8'hF, D_MSG, 1, 0));
    o32.bdi_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++)
          send(0, D_MSG, 8'(8'h10 + i), i == 11, 0);
      end
      begin
        n = 0;
        saw_low = 1'b0;
        while (o32.bdi_valid == '0 && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("t3_first_valid", 64'(o32.bdi_valid), 64'hF);
        snap = {o32.bdi, o32.bdi_valid, o32.bdi_type,
                o32.bdi_eot, o32.bdi_eoi};
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          chk("t3_hold", 64'({o32.bdi, o32.bdi_valid,
              o32.bdi_type, o32.bdi_eot, o32.bdi_eoi}),
              64'(snap));
          if (!b32.s_ready) saw_low = 1'b1;
        end
        chk("t3_sready_drop", 64'(saw_low), 64'h1);
        @(posedge clk) #1;
        o32.bdi_ready = 1'b1;
      end
    join

    // type switch without s_last closes the AD word
    repeat (6) @(posedge clk);
    #1;
    q32.push_back(mk(64'h00000201, 8'h3, D_AD, 0, 0));
    q32.push_back(mk(64'h00000003, 8'h1, D_MSG, 1, 1));
    send(0, D_AD, 8'h01, 0, 0);
    send(0, D_AD, 8'h02, 0, 0);
    set_in(0, D_MSG, 8'h03, 1, 1);
    @(negedge clk);
    chk("t4_sready_low", 64'(b32.s_ready), 64'h0);
    send(0, D_MSG, 8'h03, 1, 1);

    // asynchronous reset drops a stalled word and a partial one
    repeat (6) @(posedge clk);
    #1;
    o32.bdi_ready = 1'b0;
    send(0, D_TAG, 8'hC0, 0, 0);
    send(0, D_TAG, 8'hC1, 0, 0);
    send(0, D_TAG, 8'hC2, 0, 0);
    send(0, D_TAG, 8'hC3, 1, 0);
    send(0, D_AD, 8'hD0, 0, 0);
    send(0, D_AD, 8'hD1, 0, 0);
    send(0, D_AD, 8'hD2, 0, 0);
    chk("t5_pre_valid", 64'(o32.bdi_valid), 64'hF);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", 64'(o32.bdi_valid), 64'h0);
    chk("t5_async_sready", 64'(b32.s_ready), 64'h1);
    @(negedge clk) rst = 1'b0;
    o32.bdi_ready = 1'b1;
    @(posedge clk) #1;
    q32.push_back(mk(64'h00000055, 8'h1, D_MSG, 1, 0));
    send(0, D_MSG, 8'h55, 1, 0);

    n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    chk("q32_drained", 64'(q32.size()), 64'h0);
    chk("q64_drained", 64'(q64.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
